data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised word-wide data memory for the MEM stage; successor to the fixed 16x8 register memory.
//  Adds byte-enable writes, a registered read with valid, and a reset-time init sequencer.
//  After reset the sequencer loads word i with i+1; a ready flag gates pipeline access.
//  Addressed by the ALU result (byte address).
// PARAMETERS
//  DATA_W  32  word width in bits; multiple of 8
//  DEPTH   16  number of words; power of 2, >= 2
//  ADDR_W  32  width of the byte address (ALU output)
//  Derived: NB = DATA_W/8 bytes, OFF_W = $clog2(NB), IDX_W = $clog2(DEPTH)
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       synchronous, active-high reset
//  mem_write  in   1       write request
//  mem_read   in   1       read request
//  addr       in   ADDR_W  byte address; word index = addr[OFF_W+IDX_W-1:OFF_W]
//  wdata      in   DATA_W  write data
//  byte_en    in   NB      per-byte write enable; bit k covers wdata[8k+7:8k]
//  rdata      out  DATA_W  registered read data
//  rd_valid   out  1       rdata is valid this cycle (1-cycle pulse per read)
//  ready      out  1       memory accepts requests
//  err        out  1       access error; only driven with DMEM_RANGE_CHECK_EN
// BEHAVIOUR
//  Reset (clk edge with reset=1): state<=DM_INIT, init_ptr<=0, rdata<=0, rd_valid<=0, ready<=0, err<=0.
//  DM_INIT: one word per cycle, mem[init_ptr] <= init_ptr+1 (zero-extended), init_ptr++.
//    After writing word DEPTH-1: go to DM_RUN, ready<=1. ready rises on the DEPTH-th edge after reset drops.
//  DM_INIT: mem_read/mem_write are ignored. No write, no rd_valid, err stays 0.
//  DM_RUN write (mem_write=1): at the edge, each byte with byte_en[k]=1 is updated; other bytes hold.
//  DM_RUN read (mem_read=1): the next cycle has rdata=mem[idx] and rd_valid=1. Read latency is 1.
//    No read: rd_valid=0 and rdata holds its last value.
//  Read and write in the same cycle, same index: read-first, so rdata returns the pre-write word.
//    The write still commits. Different indices are independent.
//  byte_en=0 with mem_write=1: no change; this is not an error.
//  Address bits above OFF_W+IDX_W are ignored: the index wraps modulo DEPTH. Offset bits addr[OFF_W-1:0] are ignored.
//  Reset while in DM_INIT or DM_RUN restarts the init sequence from 0.
//    All prior writes are overwritten; a pending rd_valid is cleared.
//  State machine: DM_INIT -> DM_RUN when init_ptr==DEPTH-1; DM_RUN -> DM_INIT only on reset.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined: the access is flagged when either holds:
//    - addr[ADDR_W-1:OFF_W+IDX_W] != 0 (out of range);
//    - addr[OFF_W-1:0] != 0 (misaligned).
//    A flagged write commits nothing. A flagged read returns rdata=0 with rd_valid=1.
//    err pulses 1 for one cycle, aligned with rd_valid (or the cycle after a write).
//  DMEM_RANGE_CHECK_EN undefined: err is tied to 0, and wrap/ignore rules above apply.
// STRUCTURE
//  Package dmem_pkg:
//    - typedef enum {DM_INIT, DM_RUN} dmem_state_t;
//    - localparam BYTE_W=8;
//    - function init_word(idx) returning idx+1.
//  Sub-module dmem_lane: one 8-bit column of DEPTH entries, with write enable and a combinational read at idx.
//    Instantiated NB times. The top holds the FSM, init mux, read register and error logic.
// TESTING (defaults DATA_W=32, DEPTH=16)
//  1. reset=1 for 1 cycle, then 0 -> ready=0 for 15 edges, 1 on the 16th.
//     Then read addr 0x0C -> next cycle rdata=0x00000004, rd_valid=1.
//  2. Write addr 0x08, wdata 0xAABBCCDD, byte_en 4'b0101 -> a read of 0x08 returns 0x00BB00DD.
//  3. Same cycle: read and write addr 0x04, wdata 0x12345678, byte_en 4'hF.
//     -> rdata=0x00000002; a following read returns 0x12345678.
//  4. During init, mem_write to 0x3C with 0xFFFFFFFF plus mem_read
//     -> no rd_valid; after ready, 0x3C reads 0x00000010.
//  5. After test 2, assert reset for 1 cycle in the same cycle as a read.
//     -> rd_valid=0, ready=0; after re-init, 0x08 reads 0x00000003.
//  6. DMEM_RANGE_CHECK_EN: read 0x41, then write 0x40 with 0xDEADBEEF.
//     -> err=1 with rdata=0; word 0 still reads 0x00000001.
//     Without the macro: 0x40 writes word 0 and err stays 0.

Source files
------------

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_pkg
// Brief    : Shared types and helpers for the data memory controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

    typedef enum logic [0:0] {
        DM_INIT = 1'b0,
        DM_RUN  = 1'b1
    } dmem_state_t;

    localparam int BYTE_W = 8;

    function automatic logic [31:0] init_word(input logic [31:0] idx);
        return idx + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lane.sv
//------------------------------------------------------------------------------
// Module   : dmem_lane
// Brief    : One byte-wide column of the data memory; sync write, comb read.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
//------------------------------------------------------------------------------
// Module   : data_mem_ctrl
// Brief    : Byte-enable data memory with registered read and reset-time init.
//            Optional address checking enabled by DMEM_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_write,
    input  logic                     mem_read,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [(DATA_W/8)-1:0]    byte_en,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rd_valid,
    output logic                     ready,
    output logic                     err
);

    localparam int c_NB    = DATA_W / BYTE_W;
    localparam int c_OFF_W = $clog2(c_NB);
    localparam int c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

    dmem_state_t         r_state;
    logic [c_IDX_W-1:0]  r_init_ptr;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_rd_valid;
    logic                r_ready;
    logic                r_err;

    logic                w_init;
    logic                w_flag;
    logic [c_IDX_W-1:0]  w_idx;
    logic [c_IDX_W-1:0]  w_widx;
    logic [DATA_W-1:0]   w_init_word;
    logic [DATA_W-1:0]   w_rd_word;

    assign w_init      = (r_state == DM_INIT);
    // Upper address bits drop out here, so the word index wraps modulo DEPTH.
    assign w_idx       = c_IDX_W'(addr >> c_OFF_W);
    assign w_widx      = w_init ? r_init_ptr : w_idx;
    assign w_init_word = DATA_W'(init_word(32'(r_init_ptr)));

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [ADDR_W-1:0] c_OFF_MASK = ADDR_W'((1 << c_OFF_W) - 1);
    assign w_flag = ((addr >> (c_OFF_W + c_IDX_W)) != '0) || ((addr & c_OFF_MASK) != '0);
`else
    logic w_unused_addr;
    assign w_unused_addr = ^addr;
    assign w_flag        = 1'b0;
`endif

    for (genvar k = 0; k < c_NB; k++) begin : g_lane
        logic              w_we;
        logic [BYTE_W-1:0] w_wbyte;
        logic [BYTE_W-1:0] w_rbyte;

        assign w_we    = w_init | (mem_write & byte_en[k] & ~w_flag);
        assign w_wbyte = w_init ? w_init_word[k*BYTE_W +: BYTE_W] : wdata[k*BYTE_W +: BYTE_W];

        dmem_lane #(
            .DEPTH (DEPTH),
            .IDX_W (c_IDX_W)
        ) u_lane (
            .clk     (clk),
            .i_we    (w_we),
            .i_widx  (w_widx),
            .i_wdata (w_wbyte),
            .i_ridx  (w_idx),
            .o_rdata (w_rbyte)
        );

        assign w_rd_word[k*BYTE_W +: BYTE_W] = w_rbyte;
    end

    // Lane reads are combinational on the pre-edge array, giving read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= DM_INIT;
            r_init_ptr <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                DM_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == c_LAST_IDX) begin
                        r_state <= DM_RUN;
                        r_ready <= 1'b1;
                    end
                end
                DM_RUN: begin
                    if (mem_read) begin
                        r_rd_valid <= 1'b1;
                        r_rdata    <= w_flag ? '0 : w_rd_word;
                    end
                    r_err <= w_flag & (mem_read | mem_write);
                end
                default: r_state <= DM_INIT;
            endcase
        end
    end

    assign rdata    = r_rdata;
    assign rd_valid = r_rd_valid;
    assign ready    = r_ready;
    assign err      = r_err;

endmodule

`default_nettype wire
